// File: rtl/icache_sa_if.sv
// Bundle of fetch-side and next-level-memory signals for icache_sa.
// slave is the cache's view; master is the view of the fetch unit plus memory around it.
`ifndef CACHELINE_SIZE
`define CACHELINE_SIZE 16
`endif

interface icache_sa_if #(
  parameter int BLK_W  = 32,
  parameter int LINE_W = `CACHELINE_SIZE * 8
);
  logic              req;
  logic              gnt;
  logic [BLK_W-1:0]  addr;
  logic              get2;
  logic              flush;
  logic              rsp;
  logic [LINE_W-1:0] line0;
  logic [LINE_W-1:0] line1;
  logic              mem_req;
  logic [BLK_W-1:0]  mem_addr;
  logic              mem_gnt;
  logic              mem_rsp;
  logic [LINE_W-1:0] mem_data;

  modport slave (
    input  req, addr, get2, flush, mem_gnt, mem_rsp, mem_data,
    output gnt, rsp, line0, line1, mem_req, mem_addr
  );

  modport master (
    output req, addr, get2, flush, mem_gnt, mem_rsp, mem_data,
    input  gnt, rsp, line0, line1, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache: two-stage lookup of one or two consecutive lines,
// per-set round-robin replacement, blocking serial refill, and single-cycle flush.
`ifndef CACHELINE_SIZE
`define CACHELINE_SIZE 16
`endif

module icache_sa #(
  parameter int SETS       = 32,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = `CACHELINE_SIZE,
  parameter int BLK_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  icache_sa_if.slave  bus
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = BLK_W - IDX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] REPLAY = 2'd3;

  logic [LINE_W-1:0] data_q  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [WAY_W-1:0]  rr_q    [SETS];

  logic [1:0]        state_q;
  logic              s1_valid_q;
  logic              s1_get2_q;
  logic [BLK_W-1:0]  s1_addr_q;
  logic [BLK_W-1:0]  s1_addr1;
  logic [BLK_W-1:0]  target_q;
  logic              target_l1_q;
  logic              rsp_q;
  logic [LINE_W-1:0] line0_q;
  logic [LINE_W-1:0] line1_q;

  logic [IDX_W-1:0]  set0, set1, refill_set;
  logic [TAG_W-1:0]  tag0, tag1;
  logic [WAY_W-1:0]  refill_way;
  logic              hit0, hit1;
  logic [LINE_W-1:0] data0, data1;
  logic              s1_hit, s1_miss, rsp_next, flush_take, refill;

  // Wraps modulo 2^BLK_W; consecutive lines always land in different sets.
  assign s1_addr1   = s1_addr_q + BLK_W'(1);
  assign set0       = s1_addr_q[IDX_W-1:0];
  assign tag0       = s1_addr_q[BLK_W-1:IDX_W];
  assign set1       = s1_addr1[IDX_W-1:0];
  assign tag1       = s1_addr1[BLK_W-1:IDX_W];
  assign refill_set = target_q[IDX_W-1:0];
  assign refill_way = rr_q[refill_set];

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    hit0  = 1'b0;
    hit1  = 1'b0;
    data0 = '0;
    data1 = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[set0][w] && tag_q[set0][w] == tag0) begin
        hit0  = 1'b1;
        data0 = data0 | data_q[set0][w];
      end
      if (valid_q[set1][w] && tag_q[set1][w] == tag1) begin
        hit1  = 1'b1;
        data1 = data1 | data_q[set1][w];
      end
    end
  end

  assign s1_hit     = s1_valid_q & hit0 & (~s1_get2_q | hit1);
  assign s1_miss    = s1_valid_q & ~(hit0 & (~s1_get2_q | hit1));
  assign rsp_next   = s1_hit & ((state_q == IDLE) | (state_q == REPLAY));
  assign flush_take = bus.flush & (state_q == IDLE) & ~s1_miss;
  assign refill     = (state_q == WAIT) & bus.mem_rsp;

  assign bus.gnt      = bus.req & (state_q == IDLE) & ~bus.flush & ~s1_miss;
  assign bus.rsp      = rsp_q;
  assign bus.line0    = line0_q;
  assign bus.line1    = line1_q;
  assign bus.mem_req  = (state_q == REQ);
  assign bus.mem_addr = (state_q == REQ) ? target_q : '0;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      s1_valid_q  <= 1'b0;
      s1_get2_q   <= 1'b0;
      s1_addr_q   <= '0;
      target_q    <= '0;
      target_l1_q <= 1'b0;
      rsp_q       <= 1'b0;
      line0_q     <= '0;
      line1_q     <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      rsp_q   <= rsp_next;
      line0_q <= rsp_next ? data0 : '0;
      line1_q <= (rsp_next && s1_get2_q) ? data1 : '0;

      // A missing s1 entry stays frozen until the REPLAY compare hits.
      if (bus.gnt) begin
        s1_valid_q <= 1'b1;
        s1_addr_q  <= bus.addr;
        s1_get2_q  <= bus.get2;
      end else if (!s1_miss) begin
        s1_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (s1_miss) begin
            state_q     <= REQ;
            target_q    <= hit0 ? s1_addr1 : s1_addr_q;
            target_l1_q <= hit0;
          end
        end
        REQ: begin
          if (bus.mem_gnt) state_q <= WAIT;
        end
        WAIT: begin
          if (bus.mem_rsp) begin
            if (!target_l1_q && s1_get2_q && !hit1) begin
              state_q     <= REQ;
              target_q    <= s1_addr1;
              target_l1_q <= 1'b1;
            end else begin
              state_q <= REPLAY;
            end
          end
        end
        REPLAY:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (flush_take) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[s] <= '0;
          rr_q[s]    <= '0;
        end
      end else if (refill) begin
        valid_q[refill_set][refill_way] <= 1'b1;
        rr_q[refill_set] <= (rr_q[refill_set] == WAY_W'(WAYS - 1)) ? '0 : rr_q[refill_set] + 1'b1;
      end
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits alone decide whether a way can hit.
  always_ff @(posedge clk) begin
    if (refill && !rst) begin
      data_q[refill_set][refill_way] <= bus.mem_data;
      tag_q[refill_set][refill_way]  <= target_q[BLK_W-1:IDX_W];
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Randomised scoreboard bench for icache_sa: a FIFO-per-set residency model predicts
// refills and returned data; separate monitors check responses and memory requests.
`ifndef CACHELINE_SIZE
`define CACHELINE_SIZE 16
`endif

module tb_icache_sa;
  localparam int SETS   = 32;
  localparam int WAYS   = 4;
  localparam int LB     = `CACHELINE_SIZE;
  localparam int LINE_W = LB * 8;
  localparam int BLK_W  = 32;

  typedef logic [BLK_W-1:0]  addr_t;
  typedef logic [LINE_W-1:0] line_t;
  typedef struct {
    line_t l0;
    line_t l1;
    int    acc;
    int    nref;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  icache_sa_if #(.BLK_W(BLK_W), .LINE_W(LINE_W)) bus();

  icache_sa #(.SETS(SETS), .WAYS(WAYS), .LINE_BYTES(LB), .BLK_W(BLK_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    errors = 0;
  int    checks = 0;
  exp_t  exp_q[$];
  addr_t mem_exp_q[$];
  addr_t set_q[SETS][$];
  line_t line_store[addr_t];
  bit    ident_mode = 1'b0;
  bit    mem_busy   = 1'b0;
  int    gd_min = 0, gd_max = 0, rd_min = 3, rd_max = 3;
  int    last_mem_rsp_cyc = 0;

  task automatic check(input string name, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory contents: a fixed function of the line address, or bytes = index in ident mode.
  function automatic line_t mem_value(input addr_t a);
    line_t v;
    for (int i = 0; i < LB; i++)
      v[i*8 +: 8] = ident_mode ? 8'(i) : ((a[7:0] + 8'(i * 37)) ^ a[15:8] ^ a[23:16] ^ a[31:24]);
    return v;
  endfunction

  function automatic bit resident(input addr_t a);
    int s = int'(a % SETS);
    for (int i = 0; i < set_q[s].size(); i++)
      if (set_q[s][i] == a) return 1'b1;
    return 1'b0;
  endfunction

  // Round-robin fill order is oldest-first eviction within a set.
  function automatic void fill(input addr_t a);
    int s = int'(a % SETS);
    if (set_q[s].size() == WAYS) void'(set_q[s].pop_front());
    set_q[s].push_back(a);
    line_store[a] = mem_value(a);
    mem_exp_q.push_back(a);
  endfunction

  function automatic void model_accept(input addr_t a, input bit g2);
    exp_t  e;
    addr_t a1 = a + 1;
    e.nref = 0;
    e.acc  = cyc;
    if (!resident(a)) begin fill(a); e.nref++; end
    e.l0 = line_store[a];
    e.l1 = '0;
    if (g2) begin
      if (!resident(a1)) begin fill(a1); e.nref++; end
      e.l1 = line_store[a1];
    end
    exp_q.push_back(e);
  endfunction

  function automatic void model_clear(input bit all);
    for (int s = 0; s < SETS; s++) set_q[s].delete();
    if (all) begin
      exp_q.delete();
      mem_exp_q.delete();
    end
  endfunction

  task automatic issue(input addr_t a, input bit g2);
    int t = 0;
    bus.req  = 1'b1;
    bus.addr = a;
    bus.get2 = g2;
    @(negedge clk);
    while (!bus.gnt && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("gnt_timeout", line_t'(bus.gnt), 1);
    else          model_accept(a, g2);
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || mem_busy) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 1000) check("idle_timeout", line_t'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic flush_pulse(input addr_t a);
    bus.flush = 1'b1;
    bus.req   = 1'b1;
    bus.addr  = a;
    bus.get2  = 1'b0;
    @(negedge clk);
    check("gnt_in_flush", line_t'(bus.gnt), 0);
    model_clear(1'b0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.req   = 1'b0;
  endtask

  // Next-level memory: grant after a delay, return data later, check requested addresses.
  initial begin : responder
    addr_t a0, exp_a;
    int    gd, rd;
    bus.mem_gnt  = 1'b0;
    bus.mem_rsp  = 1'b0;
    bus.mem_data = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !rst) begin
        mem_busy = 1'b1;
        a0 = bus.mem_addr;
        if (mem_exp_q.size() == 0) begin
          check("unexpected_mem_req", line_t'(bus.mem_req), 0);
          exp_a = a0;
        end else begin
          exp_a = mem_exp_q.pop_front();
        end
        gd = $urandom_range(gd_max, gd_min);
        repeat (gd) @(negedge clk);
        check("mem_req_held", line_t'(bus.mem_req), 1);
        check("mem_addr_stable", line_t'(bus.mem_addr), line_t'(a0));
        check("mem_addr", line_t'(bus.mem_addr), line_t'(exp_a));
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        rd = $urandom_range(rd_max, rd_min);
        repeat (rd - 1) @(negedge clk);
        bus.mem_rsp  = 1'b1;
        bus.mem_data = mem_value(a0);
        last_mem_rsp_cyc = cyc;
        @(negedge clk);
        bus.mem_rsp  = 1'b0;
        bus.mem_data = '0;
        mem_busy = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : rsp_monitor
    exp_t e;
    if (!rst) begin
      if (bus.rsp) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", line_t'(bus.rsp), 0);
        end else begin
          e = exp_q.pop_front();
          check("line0", bus.line0, e.l0);
          check("line1", bus.line1, e.l1);
          if (e.nref == 0) check("hit_latency", line_t'(cyc), line_t'(e.acc + 2));
          else             check("miss_latency", line_t'(cyc), line_t'(last_mem_rsp_cyc + 2));
        end
      end else begin
        check("idle_line0", bus.line0, '0);
        check("idle_line1", bus.line1, '0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin : main
    addr_t a;
    int    pick;
    bus.req   = 1'b0;
    bus.addr  = '0;
    bus.get2  = 1'b0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_rsp",      line_t'(bus.rsp), 0);
    check("rst_line0",    bus.line0, '0);
    check("rst_line1",    bus.line1, '0);
    check("rst_mem_req",  line_t'(bus.mem_req), 0);
    check("rst_mem_addr", line_t'(bus.mem_addr), 0);
    check("rst_gnt",      line_t'(bus.gnt), 0);
    @(posedge clk); #1;

    // Cold miss with identity data, then back-to-back hits on the same line.
    ident_mode = 1'b1;
    issue(32'h40, 1'b0);
    wait_idle();
    repeat (4) issue(32'h40, 1'b0);
    wait_idle();
    ident_mode = 1'b0;

    // get2 with both lines missing under a slow grant, then address wrap-around.
    gd_min = 4; gd_max = 4;
    issue(32'h7F, 1'b1);
    wait_idle();
    gd_min = 0; gd_max = 2; rd_min = 1; rd_max = 4;
    issue(32'hFFFF_FFFF, 1'b1);
    wait_idle();

    // Replacement in set 0 from a clean cache.
    rst = 1'b1;
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) issue(addr_t'(i * 32), 1'b0);
    wait_idle();
    issue(32'h20, 1'b0);
    issue(32'h00, 1'b0);
    issue(32'h40, 1'b0);
    wait_idle();

    flush_pulse(32'h20);
    issue(32'h20, 1'b0);
    wait_idle();

    // Reset while the refill is outstanding; the late memory response must be ignored.
    gd_min = 0; gd_max = 0; rd_min = 10; rd_max = 10;
    issue(32'h123, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    model_clear(1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mem_req_after_rst", line_t'(bus.mem_req), 0);
    @(posedge clk); #1;
    wait_idle();
    rd_min = 1; rd_max = 4; gd_min = 0; gd_max = 3;
    issue(32'h123, 1'b0);
    wait_idle();

    for (int n = 0; n < 300; n++) begin
      pick = $urandom_range(0, 3);
      a = addr_t'($urandom_range(0, 5) * SETS + ((pick == 3) ? 31 : pick));
      if ($urandom_range(0, 19) == 0) begin
        wait_idle();
        flush_pulse(a);
      end
      issue(a, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    wait_idle();
    check("rsp_queue_drained", line_t'(exp_q.size()), 0);
    check("mem_queue_drained", line_t'(mem_exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
